// File: rtl/apb_slave_mem.sv
// apb_slave_mem
// APB completer backed by a flop-based register file. One transfer at a time:
// a setup phase seen in IDLE latches the request, WAIT_STATES access cycles
// are counted down, then PREADY is raised for exactly one cycle together with
// PSLVERR (address >= DEPTH) and, for reads, the new PRDATA. Writes commit on
// the completion edge (PSEL & PENABLE & PREADY). Dropping PSEL or PENABLE
// before completion aborts the transfer without side effects.
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESET   in   synchronous active-high reset (clears memory too)
//   PSEL     in   slave select
//   PENABLE  in   access phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [ADDR_WIDTH-1:0] transfer address
//   PWDATA   in   [DATA_WIDTH-1:0] write data
//   PREADY   out  registered transfer completion
//   PRDATA   out  [DATA_WIDTH-1:0] registered read data, held between reads
//   PSLVERR  out  registered error response, only high with PREADY
module apb_slave_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr_lat;
  logic [DATA_WIDTH-1:0]   wdata_lat;
  logic                    write_lat;
  logic                    err_lat;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) >= 64'(DEPTH);
  endfunction

  // Out-of-range reads return zero; the index slice is only used when in range.
  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] a);
    if (out_of_range(a)) return '0;
    return mem[a[IDX_W-1:0]];
  endfunction

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      cnt     <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only a genuine setup phase starts a transfer; PSEL&PENABLE here is ignored.
          if (PSEL && !PENABLE) begin
            addr_lat  <= PADDR;
            wdata_lat <= PWDATA;
            write_lat <= PWRITE;
            err_lat   <= out_of_range(PADDR);
            cnt       <= WAIT_INIT;
            state     <= ACCESS;
            // With no wait states the response must already be up in the
            // first access cycle, so it is built from the live setup values.
            if (WAIT_STATES == 0) begin
              PREADY  <= 1'b1;
              PSLVERR <= out_of_range(PADDR);
              if (!PWRITE) PRDATA <= read_word(PADDR);
            end
          end
        end
        ACCESS: begin
          if (!(PSEL && PENABLE)) begin
            // Abort: nothing committed, PRDATA keeps its previous response.
            state   <= IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
          end else if (PREADY) begin
            // Completion edge.
            if (write_lat && !err_lat) mem[addr_lat[IDX_W-1:0]] <= wdata_lat;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              PREADY  <= 1'b1;
              PSLVERR <= err_lat;
              if (!write_lat) PRDATA <= read_word(addr_lat);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Testbench for apb_slave_mem. Four instances with different wait-state and
// depth settings share the bus signals and are selected by their own PSEL.
//   dut 0: W=0, DEPTH=256   dut 1: W=3, DEPTH=256
//   dut 2: W=1, DEPTH=256   dut 3: W=2, DEPTH=128
module tb_apb_slave_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] psel;
  logic       penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic [3:0] pready, pslverr;
  logic [7:0] prdata [4];

  always #5 clk = ~clk;

  apb_slave_mem #(.WAIT_STATES(0)) u0 (.PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]));
  apb_slave_mem #(.WAIT_STATES(3)) u1 (.PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]));
  apb_slave_mem #(.WAIT_STATES(1)) u2 (.PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[2]), .PRDATA(prdata[2]), .PSLVERR(pslverr[2]));
  apb_slave_mem #(.WAIT_STATES(2), .DEPTH(128)) u3 (.PCLK(clk), .PRESET(rst), .PSEL(psel[3]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready[3]), .PRDATA(prdata[3]), .PSLVERR(pslverr[3]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-instance byte array plus the last read response.
  logic [7:0] mdl    [4][256];
  logic [7:0] mdl_rd [4];

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : (d == 2) ? 1 : 2;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 3) ? 128 : 256;
  endfunction

  function automatic bit err_of(input int d, input logic [7:0] a);
    return int'(a) >= depth_of(d);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 4; d++) begin
      mdl_rd[d] = 8'h00;
      for (int a = 0; a < 256; a++) mdl[d][a] = 8'h00;
    end
  endtask

  // Completed transfer: writes land unless out of range, reads update the response.
  task automatic model_apply(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd);
    if (wr) begin
      if (!err_of(d, a)) mdl[d][a] = wd;
    end else begin
      mdl_rd[d] = err_of(d, a) ? 8'h00 : mdl[d][a];
    end
  endtask

  // Drives one transfer; called and returning at 1 time unit after a rising edge.
  // rdy_k: access-cycle index where PREADY was first seen (-1 if none).
  // bad:   PREADY during setup, PSLVERR without PREADY, or PREADY in the abort cycle.
  // The bus is scrambled during access cycles: only latched values may matter.
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                      input int abort_at, output int rdy_k, output bit err_o,
                      output logic [7:0] rd_o, output bit bad);
    rdy_k = -1; err_o = 1'b0; rd_o = 8'h00; bad = 1'b0;
    psel = 4'b0; psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    @(negedge clk);
    if (pready[d] || pslverr[d]) bad = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      penable = (k != abort_at);
      pwrite  = 1'($urandom);
      paddr   = 8'($urandom);
      pwdata  = 8'($urandom);
      @(negedge clk);
      if (pslverr[d] && !pready[d]) bad = 1'b1;
      if (k == abort_at) begin
        if (pready[d]) bad = 1'b1;
        break;
      end
      if (pready[d]) begin
        rdy_k = k; err_o = pslverr[d]; rd_o = prdata[d];
        break;
      end
    end
    @(posedge clk); #1;
    psel = 4'b0; penable = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  int         rk;
  bit         eo, bd;
  logic [7:0] rd;

  task automatic test_reset();
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_tests++; if (pready[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pready[%0d]: got %b want 0", d, pready[d]); end
      n_tests++; if (pslverr[d] !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr[%0d]: got %b want 0", d, pslverr[d]); end
      n_tests++; if (prdata[d] !== 8'h00) begin n_fail++; $display("FAIL reset_prdata[%0d]: got %h want 00", d, prdata[d]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_w0_write_read();
    xfer(0, 1'b1, 8'h10, 8'hA5, -1, rk, eo, rd, bd); model_apply(0, 1'b1, 8'h10, 8'hA5);
    n_tests++; if (rk !== 0) begin n_fail++; $display("FAIL w0_wr_ready_cycle: got %0d want 0", rk); end
    n_tests++; if (eo !== 1'b0 || bd) begin n_fail++; $display("FAIL w0_wr_err: got err=%b bad=%b want 0", eo, bd); end
    @(negedge clk);
    n_tests++; if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL w0_ready_drop: got %b want 0", pready[0]); end
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h10, 8'h00, -1, rk, eo, rd, bd); model_apply(0, 1'b0, 8'h10, 8'h00);
    n_tests++; if (rk !== 0) begin n_fail++; $display("FAIL w0_rd_ready_cycle: got %0d want 0", rk); end
    n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL w0_rd_data: got %h want a5", rd); end
    n_tests++; if (eo !== 1'b0 || bd) begin n_fail++; $display("FAIL w0_rd_err: got err=%b bad=%b want 0", eo, bd); end
    idle_cycles(2);
    n_tests++; if (prdata[0] !== 8'hA5) begin n_fail++; $display("FAIL w0_rd_hold: got %h want a5", prdata[0]); end
  endtask

  task automatic test_w3_read();
    xfer(1, 1'b1, 8'h10, 8'hA5, -1, rk, eo, rd, bd); model_apply(1, 1'b1, 8'h10, 8'hA5);
    n_tests++; if (rk !== 3 || bd) begin n_fail++; $display("FAIL w3_wr_ready_cycle: got %0d bad=%b want 3", rk, bd); end
    xfer(1, 1'b0, 8'h10, 8'h00, -1, rk, eo, rd, bd); model_apply(1, 1'b0, 8'h10, 8'h00);
    n_tests++; if (rk !== 3 || bd) begin n_fail++; $display("FAIL w3_rd_ready_cycle: got %0d bad=%b want 3", rk, bd); end
    n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL w3_rd_data: got %h want a5", rd); end
    idle_cycles(1);
  endtask

  task automatic test_error();
    xfer(3, 1'b1, 8'h00, 8'h11, -1, rk, eo, rd, bd); model_apply(3, 1'b1, 8'h00, 8'h11);
    xfer(3, 1'b1, 8'h80, 8'h3C, -1, rk, eo, rd, bd); model_apply(3, 1'b1, 8'h80, 8'h3C);
    n_tests++; if (rk !== 2 || eo !== 1'b1 || bd) begin n_fail++; $display("FAIL err_wr: got rdy=%0d err=%b bad=%b want rdy=2 err=1", rk, eo, bd); end
    xfer(3, 1'b0, 8'h80, 8'h00, -1, rk, eo, rd, bd); model_apply(3, 1'b0, 8'h80, 8'h00);
    n_tests++; if (rk !== 2 || eo !== 1'b1 || bd) begin n_fail++; $display("FAIL err_rd: got rdy=%0d err=%b bad=%b want rdy=2 err=1", rk, eo, bd); end
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL err_rd_data: got %h want 00", rd); end
    xfer(3, 1'b0, 8'h00, 8'h00, -1, rk, eo, rd, bd); model_apply(3, 1'b0, 8'h00, 8'h00);
    n_tests++; if (rd !== 8'h11 || eo !== 1'b0) begin n_fail++; $display("FAIL err_mem_intact: got %h err=%b want 11 err=0", rd, eo); end
    idle_cycles(1);
  endtask

  task automatic test_abort();
    xfer(3, 1'b1, 8'h20, 8'h55, -1, rk, eo, rd, bd); model_apply(3, 1'b1, 8'h20, 8'h55);
    xfer(3, 1'b1, 8'h20, 8'h77, 1, rk, eo, rd, bd);
    n_tests++; if (rk !== -1 || bd) begin n_fail++; $display("FAIL abort_no_ready: got rdy=%0d bad=%b want none", rk, bd); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++; if (pready[3] !== 1'b0 || pslverr[3] !== 1'b0) begin
        n_fail++; $display("FAIL abort_idle: got ready=%b err=%b want 0", pready[3], pslverr[3]); end
      @(posedge clk); #1;
    end
    xfer(3, 1'b0, 8'h20, 8'h00, -1, rk, eo, rd, bd); model_apply(3, 1'b0, 8'h20, 8'h00);
    n_tests++; if (rd !== 8'h55 || rk !== 2) begin n_fail++; $display("FAIL abort_old_value: got %h rdy=%0d want 55 rdy=2", rd, rk); end
    idle_cycles(1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      xfer(2, 1'b1, 8'(i), 8'(i + 1), -1, rk, eo, rd, bd); model_apply(2, 1'b1, 8'(i), 8'(i + 1));
      n_tests++; if (rk !== 1 || bd) begin n_fail++; $display("FAIL b2b_wr%0d: got rdy=%0d bad=%b want rdy=1", i, rk, bd); end
    end
    for (int i = 0; i < 4; i++) begin
      xfer(2, 1'b0, 8'(i), 8'h00, -1, rk, eo, rd, bd); model_apply(2, 1'b0, 8'(i), 8'h00);
      n_tests++; if (rk !== 1 || bd || rd !== 8'(i + 1)) begin
        n_fail++; $display("FAIL b2b_rd%0d: got rdy=%0d bad=%b data=%h want rdy=1 data=%h", i, rk, bd, rd, 8'(i + 1)); end
    end
    idle_cycles(1);
  endtask

  task automatic test_enable_in_idle();
    psel = 4'b0001; penable = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (pready[0] !== 1'b0) begin n_fail++; $display("FAIL idle_enable_ignored: got %b want 0", pready[0]); end
      @(posedge clk); #1;
    end
    psel = 4'b0; penable = 1'b0;
    idle_cycles(1);
    xfer(0, 1'b0, 8'h10, 8'h00, -1, rk, eo, rd, bd); model_apply(0, 1'b0, 8'h10, 8'h00);
    n_tests++; if (rd !== mdl_rd[0] || rk !== 0) begin n_fail++; $display("FAIL idle_enable_no_write: got %h want %h", rd, mdl_rd[0]); end
    idle_cycles(1);
  endtask

  task automatic test_random();
    int d, ab, exp_rk;
    bit wr;
    logic [7:0] a, wd;
    for (int it = 0; it < 150; it++) begin
      d  = int'($urandom_range(0, 3));
      wr = 1'($urandom);
      a  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      if ($urandom_range(0, 3) == 0) a[7] = 1'b1;
      wd = 8'($urandom);
      ab = (wait_of(d) > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, wait_of(d) - 1)) : -1;
      xfer(d, wr, a, wd, ab, rk, eo, rd, bd);
      exp_rk = (ab >= 0) ? -1 : wait_of(d);
      if (ab < 0) model_apply(d, wr, a, wd);
      n_tests++; if (rk !== exp_rk || bd) begin
        n_fail++; $display("FAIL rnd%0d_ready: dut%0d got rdy=%0d bad=%b want %0d", it, d, rk, bd, exp_rk); end
      if (ab < 0) begin
        n_tests++; if (eo !== err_of(d, a) || rd !== mdl_rd[d]) begin
          n_fail++; $display("FAIL rnd%0d_resp: dut%0d a=%h got err=%b data=%h want err=%b data=%h",
                             it, d, a, eo, rd, err_of(d, a), mdl_rd[d]); end
      end
      if ($urandom_range(0, 2) == 0) idle_cycles(1);
    end
  endtask

  task automatic test_reset_after_writes();
    xfer(2, 1'b1, 8'h44, 8'h99, -1, rk, eo, rd, bd); model_apply(2, 1'b1, 8'h44, 8'h99);
    xfer(2, 1'b0, 8'h44, 8'h00, -1, rk, eo, rd, bd); model_apply(2, 1'b0, 8'h44, 8'h00);
    n_tests++; if (rd !== 8'h99) begin n_fail++; $display("FAIL pre_reset_read: got %h want 99", rd); end
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    n_tests++; if (pready[2] !== 1'b0 || pslverr[2] !== 1'b0 || prdata[2] !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_outputs: got ready=%b err=%b data=%h want 0 0 00", pready[2], pslverr[2], prdata[2]); end
    @(posedge clk); #1;
    xfer(2, 1'b0, 8'h44, 8'h00, -1, rk, eo, rd, bd); model_apply(2, 1'b0, 8'h44, 8'h00);
    n_tests++; if (rd !== 8'h00 || rk !== 1) begin n_fail++; $display("FAIL post_reset_read44: got %h rdy=%0d want 00 rdy=1", rd, rk); end
    xfer(0, 1'b0, 8'h10, 8'h00, -1, rk, eo, rd, bd); model_apply(0, 1'b0, 8'h10, 8'h00);
    n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL post_reset_read10: got %h want 00", rd); end
    // Reset in the middle of a W=3 write: the write is lost and the FSM restarts cleanly.
    psel = 4'b0010; penable = 1'b0; pwrite = 1'b1; paddr = 8'h50; pwdata = 8'hCC;
    idle_cycles(1);
    penable = 1'b1;
    idle_cycles(1);
    rst = 1'b1;
    idle_cycles(1);
    rst = 1'b0; psel = 4'b0; penable = 1'b0;
    @(negedge clk);
    n_tests++; if (pready[1] !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 0", pready[1]); end
    @(posedge clk); #1;
    model_clear();
    xfer(1, 1'b0, 8'h50, 8'h00, -1, rk, eo, rd, bd); model_apply(1, 1'b0, 8'h50, 8'h00);
    n_tests++; if (rd !== 8'h00 || rk !== 3 || bd) begin
      n_fail++; $display("FAIL mid_reset_read: got %h rdy=%0d bad=%b want 00 rdy=3", rd, rk, bd); end
  endtask

  initial begin
    rst = 1'b1; psel = 4'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_w0_write_read();
    test_w3_read();
    test_error();
    test_abort();
    test_back_to_back();
    test_enable_in_idle();
    test_random();
    test_reset_after_writes();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
